mmio_uart_tx: RTL



---
 rtl/mmio_uart_tx_pkg.sv | 35 +++
 rtl/uart_tx_fifo.sv | 47 ++++
 rtl/mmio_uart_tx.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// rtl/mmio_uart_tx_pkg.sv - register offsets, status bit positions and TX FSM encodings
`timescale 1ns/1ps
package mmio_uart_tx_pkg;

    localparam logic [31:0] UART_TXDATA_OFF = 32'd0;
    localparam logic [31:0] UART_STATUS_OFF = 32'd4;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_FULL_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    function automatic logic [31:0] status_word(
        input logic ovf,
        input logic full,
        input logic empty,
        input logic busy
    );
        logic [31:0] w;
        w                 = 32'd0;
        w[STAT_OVF_BIT]   = ovf;
        w[STAT_FULL_BIT]  = full;
        w[STAT_EMPTY_BIT] = empty;
        w[STAT_BUSY_BIT]  = busy;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO with wrap-bit pointers
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [7:0]  r_mem [DEPTH];
    logic        w_do_pop;
    logic        w_do_push;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    // A push into a full FIFO is still legal when the head leaves the same cycle.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TXDATA/STATUS window
`timescale 1ns/1ps
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_FF00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
    input  logic        memWrite,
    input  logic        memRead,
    output logic        hit,
    output logic [31:0] readData,
    output logic        txd,
    output logic        busy
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         r_state;
    tx_state_t         w_state_next;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_next;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_next;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic              r_txd;
    logic              w_txd_next;
    logic              r_busy;
    logic              r_overflow;

    logic              w_hit_tx;
    logic              w_hit_st;
    logic              w_wr_tx;
    logic              w_drop;
    logic              w_clr_ovf;
    logic              w_pop;
    logic              w_baud_done;
    logic [7:0]        w_fifo_dout;
    logic              w_full;
    logic              w_empty;
    logic [31:0]       w_status;
    logic [23:0]       w_unused_wdata;

    assign w_hit_tx = (addr == BASE_ADDR + UART_TXDATA_OFF);
    assign w_hit_st = (addr == BASE_ADDR + UART_STATUS_OFF);
    assign hit      = w_hit_tx || w_hit_st;

    assign w_status = status_word(r_overflow, w_full, w_empty, r_busy);
    assign readData = (memRead && w_hit_st) ? w_status : 32'd0;

    assign w_wr_tx        = memWrite && w_hit_tx;
    assign w_drop         = w_wr_tx && w_full && !w_pop;
    assign w_clr_ovf      = memWrite && w_hit_st && writeData[STAT_OVF_BIT];
    assign w_unused_wdata = writeData[31:8];

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_wr_tx),
        .pop   (w_pop),
        .din   (writeData[7:0]),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (w_clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign w_baud_done = (r_baud == BAUD_LAST);

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_baud_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_dout;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_bit_next   = 3'd0;
                    w_state_next = ST_DATA;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            ST_DATA: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            ST_STOP: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    // Chain straight into the next start bit so queued bytes leave gap-free.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_dout;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            ST_START: w_txd_next = 1'b0;
            ST_DATA:  w_txd_next = w_shift_next[0];
            default:  w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_next;
            r_shift   <= w_shift_next;
            r_txd     <= w_txd_next;
            r_busy    <= (w_state_next != ST_IDLE);
        end
    end

    assign txd  = r_txd;
    assign busy = r_busy;

endmodule
